adc_serial_capture: RTL
=======================

// Module: adc_serial_capture
// PURPOSE
//  Upstream feeder for the AHB-lite ADC slave.
//  Periodically runs a serial (SPI-style, read-only) conversion frame on an external ADC.
//  Deserialises DATA_WIDTH result bits and presents them on data_out, held stable until the next frame.
//  data_out drives the slave's data_in; data_valid marks each fresh sample for the PID path.
// PARAMETERS
//  DATA_WIDTH     8    result bits captured per frame (MSB first)
//  FRAME_BITS     16   SCLK cycles per frame; must be >= LEAD_BITS+DATA_WIDTH
//  LEAD_BITS      4    leading bits discarded before the result MSB
//  CLK_DIV        2    HCLK cycles per SCLK half-period; >= 1
//  SAMPLE_PERIOD  100  HCLK cycles between frame starts; >= CLK_DIV*(2+2*FRAME_BITS)+2
// PORTS
//  HCLK         in   1           system clock
//  HRESETn      in   1           asynchronous active-low reset
//  enable       in   1           1 = periodic sampling runs
//  adc_cs_n     out  1           ADC chip select, active low
//  adc_sclk     out  1           ADC serial clock, idles high
//  adc_sdo      in   1           ADC serial data (ADC launches on SCLK falling edge)
//  data_out     out  DATA_WIDTH  last completed sample
//  data_valid   out  1           1-cycle pulse when data_out updates
//  busy         out  1           1 while FSM is not IDLE
//  overrun      out  1           sticky: a start was dropped because a frame was in progress
// BEHAVIOUR
//  Reset (async, any time, including mid-frame) forces:
//   - adc_cs_n=1, adc_sclk=1, data_out=0, data_valid=0, busy=0, overrun=0
//   - FSM=IDLE; period, bit and divider counters = 0
//  All outputs are registered.
//  Period counter:
//   - enable=0: held at 0.
//   - enable=1: counts 0..SAMPLE_PERIOD-1, then wraps.
//   - start = enable & (count==0), so the first start occurs on the first enabled cycle.
//  FSM states: IDLE -> SETUP -> SHIFT -> QUIET -> IDLE.
//  IDLE:
//   - On start, go to SETUP; adc_cs_n goes low on that edge.
//  SETUP:
//   - CLK_DIV cycles with adc_sclk=1, then go to SHIFT.
//  SHIFT:
//   - Per bit: CLK_DIV cycles with adc_sclk=0, then CLK_DIV cycles with adc_sclk=1.
//   - adc_sdo is registered on the same HCLK edge that drives adc_sclk 0->1.
//   - Bit index b = 0..FRAME_BITS-1. Bits LEAD_BITS..LEAD_BITS+DATA_WIDTH-1 shift in MSB first; all other bits are ignored.
//   - After the high half of bit FRAME_BITS-1, on one edge: adc_cs_n<=1, data_out<=shift register, data_valid<=1 (next cycle 0). Then go to QUIET.
//  QUIET:
//   - CLK_DIV cycles with adc_cs_n=1, then go to IDLE.
//  Timing:
//   - adc_cs_n is low for exactly CLK_DIV*(1+2*FRAME_BITS) cycles (66 at defaults).
//   - data_valid rises on the same edge where adc_cs_n returns high.
//  enable deasserted mid-frame:
//   - The frame completes normally, including data_valid.
//   - The period counter clears; no new start until enable=1.
//  Dropped starts:
//   - A start arriving while FSM != IDLE is dropped and sets overrun (only possible when SAMPLE_PERIOD is out of range).
//   - overrun clears only on reset.
//  data_out is never partially updated; it changes only on data_valid edges.
//  busy=1 from the start edge through the last QUIET cycle.
// TESTING
//  Reset then idle:
//   - Hold HRESETn=0, enable=1 -> all outputs at reset values.
//   - Release with enable=0 for 500 cycles -> no activity.
//  Single frame:
//   - ADC model returns 0x0A5 in bits 4..11 of a 16-bit frame (stream 0000_1010_0101_0000).
//   - Required: data_out=0xA5, data_valid high 1 cycle, adc_cs_n low exactly 66 cycles.
//  Periodic sampling:
//   - enable=1 for 1000 cycles -> 10 frames at a 100-cycle spacing.
//   - Each data_out equals the model value for that frame (incrementing 0x00..0x09); overrun=0.
//  Boundary values:
//   - Model returns 0xFF, then 0x00, then 0x80 -> data_out reflects each exactly.
//   - Lead and trailing bits driven to 1 must not leak into data_out.
//  enable dropped mid-frame:
//   - Deassert at SHIFT bit 5 -> frame completes with valid data; no further adc_cs_n fall.
//  Reset mid-frame and overrun:
//   - Assert HRESETn=0 at bit 8 -> adc_cs_n=1 and adc_sclk=1 immediately; data_out=0.
//   - Rebuild with SAMPLE_PERIOD=40 -> overrun=1 after the 2nd start.

Source files
------------

// File: rtl/adc_serial_capture_if.sv
// Signal bundle between the ADC capture block and its neighbours (control, ADC pins, sample output).
// The master side is the capture block; the slave side is the consumer plus the external ADC.
interface adc_serial_capture_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic                  adc_cs_n;
  logic                  adc_sclk;
  logic                  adc_sdo;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    input  enable, adc_sdo,
    output adc_cs_n, adc_sclk, data_out, data_valid, busy, overrun
  );

  modport slave (
    output enable, adc_sdo,
    input  adc_cs_n, adc_sclk, data_out, data_valid, busy, overrun
  );
endinterface

// File: rtl/adc_serial_capture.sv
// Periodic read-only serial ADC frame engine; result lands on data_out with a 1-cycle data_valid,
// CLK_DIV*(1+2*FRAME_BITS) cycles after cs_n falls. No backpressure: starts arriving mid-frame are dropped and flagged.
module adc_serial_capture #(
  parameter int DATA_WIDTH    = 8,
  parameter int FRAME_BITS    = 16,
  parameter int LEAD_BITS     = 4,
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  adc_serial_capture_if.master adc
);

  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(LEAD_BITS);
  localparam logic [BIT_W-1:0] BIT_END   = BIT_W'(LEAD_BITS + DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  state_t                state_q, state_nxt;
  logic [PER_W-1:0]      per_q, per_nxt;
  logic [DIV_W-1:0]      div_q, div_nxt;
  logic [BIT_W-1:0]      bit_q, bit_nxt;
  logic                  high_q, high_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic                  cs_n_q, cs_n_nxt;
  logic                  sclk_q, sclk_nxt;
  logic [DATA_WIDTH-1:0] dout_q, dout_nxt;
  logic                  vld_q, vld_nxt;
  logic                  busy_q, busy_nxt;
  logic                  ovr_q, ovr_nxt;

  logic                  start;
  logic                  div_done;
  logic [DIV_W-1:0]      div_inc;
  logic                  bit_in_result;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      per_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      high_q  <= 1'b0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      per_q   <= per_nxt;
      div_q   <= div_nxt;
      bit_q   <= bit_nxt;
      high_q  <= high_nxt;
      shift_q <= shift_nxt;
      cs_n_q  <= cs_n_nxt;
      sclk_q  <= sclk_nxt;
      dout_q  <= dout_nxt;
      vld_q   <= vld_nxt;
      busy_q  <= busy_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    div_nxt   = div_q;
    bit_nxt   = bit_q;
    high_nxt  = high_q;
    shift_nxt = shift_q;
    cs_n_nxt  = cs_n_q;
    sclk_nxt  = sclk_q;
    dout_nxt  = dout_q;
    vld_nxt   = 1'b0;
    ovr_nxt   = ovr_q;
    per_nxt   = '0;

    if (adc.enable) begin
      per_nxt = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
    end

    start         = adc.enable && (per_q == '0);
    div_done      = (div_q == DIV_LAST);
    div_inc       = div_done ? '0 : div_q + 1'b1;
    bit_in_result = (bit_q >= BIT_FIRST) && (bit_q <= BIT_END);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
          sclk_nxt  = 1'b1;
          div_nxt   = '0;
        end
      end
      SETUP: begin
        div_nxt = div_inc;
        if (div_done) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b0;
          high_nxt  = 1'b0;
          bit_nxt   = '0;
        end
      end
      SHIFT: begin
        div_nxt = div_inc;
        if (div_done) begin
          if (!high_q) begin
            // Rising SCLK edge: ADC launched this bit on the falling edge, so it is settled now.
            sclk_nxt = 1'b1;
            high_nxt = 1'b1;
            if (bit_in_result) begin
              shift_nxt = (shift_q << 1) | DATA_WIDTH'(adc.adc_sdo);
            end
          end else if (bit_q == BIT_LAST) begin
            state_nxt = QUIET;
            cs_n_nxt  = 1'b1;
            high_nxt  = 1'b0;
            dout_nxt  = shift_q;
            vld_nxt   = 1'b1;
          end else begin
            bit_nxt  = bit_q + 1'b1;
            sclk_nxt = 1'b0;
            high_nxt = 1'b0;
          end
        end
      end
      QUIET: begin
        div_nxt = div_inc;
        if (div_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b1;
        div_nxt   = '0;
      end
    endcase

    if (start && (state_q != IDLE)) begin
      ovr_nxt = 1'b1;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  assign adc.adc_cs_n   = cs_n_q;
  assign adc.adc_sclk   = sclk_q;
  assign adc.data_out   = dout_q;
  assign adc.data_valid = vld_q;
  assign adc.busy       = busy_q;
  assign adc.overrun    = ovr_q;

endmodule
